sifive_tl_ul_ram_responder: RTL

TileLink-UL manager (responder) end of the 32-bit TL port that the TL monitor checks.
//   - Accepts A-channel Get/PutFullData/PutPartialData requests.
//   - Services them from a local single-port word SRAM.
//   - Returns AccessAckData/AccessAck on the D channel.
//   - Serves as the slave-side bench target and scratch RAM behind the TL crossbar.

---
 rtl/sifive_tl_ul_pkg.sv | 30 +++
 rtl/sifive_tl_ul_resp_fifo.sv | 54 +++++
 rtl/sifive_tl_ul_ram_responder.sv | 124 ++++++++++++
 3 files changed

// File: rtl/sifive_tl_ul_pkg.sv
// Shared TileLink-UL types for the RAM responder and its response FIFO.
package sifive_tl_ul_pkg;

    localparam int unsigned TL_DATA_W   = 32;
    localparam int unsigned TL_MASK_W   = 4;
    localparam int unsigned TL_SIZE_W   = 3;
    // Widest source ID a response beat can carry; instantiations use SOURCE_W <= this.
    localparam int unsigned TL_SOURCE_W = 7;

    typedef enum logic [2:0] {
        PUT_FULL    = 3'd0,
        PUT_PARTIAL = 3'd1,
        GET         = 3'd4
    } tl_a_op_e;

    typedef enum logic [2:0] {
        ACCESS_ACK      = 3'd0,
        ACCESS_ACK_DATA = 3'd1
    } tl_d_op_e;

    typedef struct packed {
        tl_d_op_e                 opcode;
        logic [TL_SIZE_W-1:0]     size;
        logic [TL_SOURCE_W-1:0]   source;
        logic                     denied;
        logic                     corrupt;
        logic [TL_DATA_W-1:0]     data;
    } tl_d_beat_t;

endpackage

// File: rtl/sifive_tl_ul_resp_fifo.sv
// Two-entry D-beat FIFO; an empty FIFO passes the pushed beat straight to the output.
module sifive_tl_ul_resp_fifo
    import sifive_tl_ul_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       push_valid,
    input  tl_d_beat_t push_beat,
    input  logic       pop_ready,
    output logic       out_valid,
    output tl_d_beat_t out_beat,
    output logic [1:0] count
);

    tl_d_beat_t entry0, entry1, entry0_n, entry1_n;
    logic [1:0] count_n;
    logic       out_fire, deq, store;

    // Output selection and next-state for the two slots (head is entry0).
    always_comb begin
        entry0_n  = entry0;
        entry1_n  = entry1;
        out_valid = (count != 2'd0) || push_valid;
        out_beat  = (count == 2'd0) ? push_beat : entry0;
        out_fire  = out_valid && pop_ready;
        deq       = out_fire && (count != 2'd0);
        store     = push_valid && !(out_fire && (count == 2'd0)) && ((count != 2'd2) || deq);
        if (deq) begin
            entry0_n = entry1;
        end
        if (store) begin
            if ((count - 2'(deq)) == 2'd0) begin
                entry0_n = push_beat;
            end else begin
                entry1_n = push_beat;
            end
        end
        count_n = count + 2'(store) - 2'(deq);
    end

    // Slot and occupancy registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            entry0 <= '0;
            entry1 <= '0;
            count  <= 2'd0;
        end else begin
            entry0 <= entry0_n;
            entry1 <= entry1_n;
            count  <= count_n;
        end
    end

endmodule

// File: rtl/sifive_tl_ul_ram_responder.sv
// TileLink-UL manager backed by a local byte-enable word SRAM, one-cycle response latency.
// Optional legality checking (denied/corrupt responses) is enabled by defining TL_UL_RESP_ERR_EN.
module sifive_tl_ul_ram_responder
    import sifive_tl_ul_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned ADDR_W      = 30,
    parameter int unsigned SOURCE_W    = 7,
    parameter int unsigned BASE_ADDR   = 0
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 a_valid,
    output logic                 a_ready,
    input  logic [2:0]           a_opcode,
    input  logic [2:0]           a_size,
    input  logic [SOURCE_W-1:0]  a_source,
    input  logic [ADDR_W-1:0]    a_address,
    input  logic [TL_MASK_W-1:0] a_mask,
    input  logic [TL_DATA_W-1:0] a_data,
    output logic                 d_valid,
    input  logic                 d_ready,
    output logic [2:0]           d_opcode,
    output logic [2:0]           d_size,
    output logic [SOURCE_W-1:0]  d_source,
    output logic                 d_denied,
    output logic                 d_corrupt,
    output logic [TL_DATA_W-1:0] d_data
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
    localparam int unsigned AW1   = ADDR_W + 1;

    logic [TL_DATA_W-1:0] mem [DEPTH_WORDS];

    logic              a_fire, is_get, is_put, legal, do_write, do_read;
    logic [ADDR_W-1:0] offset;
    logic [IDX_W-1:0]  word_idx;
    logic              inflight;
    tl_d_beat_t        inflight_beat, out_beat;
    logic [1:0]        fifo_count;

    assign a_fire   = a_valid && a_ready && !reset;
    assign offset   = a_address - ADDR_W'(BASE_ADDR);
    assign word_idx = offset[IDX_W+1:2];
    assign is_get   = (a_opcode == 3'(GET));
    assign is_put   = (a_opcode == 3'(PUT_FULL)) || (a_opcode == 3'(PUT_PARTIAL));

`ifdef TL_UL_RESP_ERR_EN
    localparam logic [ADDR_W:0] WINDOW_BYTES = AW1'(4 * DEPTH_WORDS);
    logic aligned;

    // Request legality: in-window, size <= word, naturally aligned, known opcode.
    always_comb begin
        aligned = 1'b0;
        case (a_size)
            3'd0:    aligned = 1'b1;
            3'd1:    aligned = !a_address[0];
            3'd2:    aligned = (a_address[1:0] == 2'd0);
            default: aligned = 1'b0;
        endcase
        legal = (a_address >= ADDR_W'(BASE_ADDR)) && ({1'b0, offset} < WINDOW_BYTES)
                && aligned && (is_get || is_put);
    end
`else
    logic unused_addr_bits;
    assign legal            = 1'b1;
    assign unused_addr_bits = ^{offset[ADDR_W-1:IDX_W+2], offset[1:0]};
`endif

    assign do_write = a_fire && legal && is_put;
    assign do_read  = a_fire && legal && is_get;

    // Byte-lane SRAM write; contents deliberately not reset.
    always_ff @(posedge clock) begin
        if (do_write) begin
            for (int unsigned b = 0; b < TL_MASK_W; b++) begin
                if (a_mask[b]) begin
                    mem[word_idx][8*b +: 8] <= a_data[8*b +: 8];
                end
            end
        end
    end

    // In-flight slot: captured request fields plus synchronous SRAM read data.
    always_ff @(posedge clock) begin
        if (reset) begin
            inflight      <= 1'b0;
            inflight_beat <= '0;
        end else begin
            inflight <= a_fire;
            if (a_fire) begin
                inflight_beat.opcode  <= is_get ? ACCESS_ACK_DATA : ACCESS_ACK;
                inflight_beat.size    <= a_size;
                inflight_beat.source  <= TL_SOURCE_W'(a_source);
                inflight_beat.denied  <= !legal;
                inflight_beat.corrupt <= !legal && is_get;
                inflight_beat.data    <= do_read ? mem[word_idx] : '0;
            end
        end
    end

    sifive_tl_ul_resp_fifo u_fifo (
        .clock      (clock),
        .reset      (reset),
        .push_valid (inflight),
        .push_beat  (inflight_beat),
        .pop_ready  (d_ready),
        .out_valid  (d_valid),
        .out_beat   (out_beat),
        .count      (fifo_count)
    );

    // Accept only while a slot is guaranteed for the response.
    assign a_ready   = ({1'b0, fifo_count} + {2'b00, inflight}) < 3'd2;

    assign d_opcode  = out_beat.opcode;
    assign d_size    = out_beat.size;
    assign d_source  = SOURCE_W'(out_beat.source);
    assign d_denied  = out_beat.denied;
    assign d_corrupt = out_beat.corrupt;
    assign d_data    = out_beat.data;

endmodule
